reg_wb_arbiter: RTL and testbench

//  Sequences the register file's single write port (we3/ad3/wd3) between two writers.
//  A = in-order pipeline writeback (primary). B = multi-cycle mul/div unit, buffered in a 2-entry FIFO.

---
 rtl/reg_wb_pkg.sv | 17 +
 rtl/wb_fifo.sv | 60 ++++++
 rtl/reg_wb_arbiter.sv | 154 +++++++++++++++
 tb/tb_reg_wb_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_pkg.sv
// Shared types for the register-file writeback arbiter: arbitration states,
// FIFO depth and the default buffered write request layout.
package reg_wb_pkg;
    typedef enum logic {
        PRIO_A  = 1'b0,
        FORCE_B = 1'b1
    } arb_state_t;

    localparam int WB_FIFO_DEPTH = 2;
    localparam int WB_AW         = 5;
    localparam int WB_DW         = 32;

    typedef struct packed {
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Two-entry FIFO for buffered mul/div writebacks; exposes every slot and its
// occupancy so the top level can compare pending destinations for hazards.
module wb_fifo
    import reg_wb_pkg::*;
#(
    parameter type req_t = wb_req_t
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  req_t                           push_req,
    output req_t                           head,
    output logic [1:0]                     count,
    output req_t [WB_FIFO_DEPTH-1:0]       entries,
    output logic [WB_FIFO_DEPTH-1:0]       entry_valid
);
    req_t [WB_FIFO_DEPTH-1:0] mem_r;
    logic                     rd_ptr_r;
    logic                     wr_ptr_r;
    logic [1:0]               count_r;
    logic                     do_push_s;
    logic                     do_pop_s;

    assign do_push_s = push && (count_r != 2'd2);
    assign do_pop_s  = pop && (count_r != 2'd0);
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign entries   = mem_r;

    // Slot occupancy: the read slot holds the head, the other slot is live only when full.
    always_comb begin
        entry_valid            = {WB_FIFO_DEPTH{1'b0}};
        entry_valid[rd_ptr_r]  = (count_r != 2'd0);
        entry_valid[~rd_ptr_r] = (count_r == 2'd2);
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_r    <= '0;
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_req;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates the register file write port between pipeline writeback (A) and
// the buffered mul/div unit (B), bounding B starvation and flagging read hazards.
module reg_wb_arbiter
    import reg_wb_pkg::*;
#(
    parameter int REG_FILE_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH          = 32,
    parameter int STARVE_LIMIT        = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           a_valid,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0]          a_data,
    output logic                           a_ready,
    input  logic                           b_valid,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0]          b_data,
    output logic                           b_ready,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] q_ad1,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] q_ad2,
    output logic                           hazard,
    output logic                           we3,
    output logic [REG_FILE_ADDR_WIDTH-1:0] ad3,
    output logic [DATA_WIDTH-1:0]          wd3
);
    localparam int AW = REG_FILE_ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int CW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    arb_state_t                state_r;
    logic [CW-1:0]             starve_cnt_r;
    logic                      a_nz_s;
    logic                      b_nz_s;
    logic                      fifo_empty_s;
    logic                      grant_a_s;
    logic                      pop_s;
    logic                      push_s;
    req_t                      push_req_s;
    req_t                      head_s;
    logic [1:0]                count_s;
    req_t [WB_FIFO_DEPTH-1:0]  entries_s;
    logic [WB_FIFO_DEPTH-1:0]  entry_valid_s;

    function automatic logic addr_match(input logic [AW-1:0] q, input logic [AW-1:0] a);
        return (q != {AW{1'b0}}) && (q == a);
    endfunction

    assign a_nz_s       = a_valid && (a_addr != {AW{1'b0}});
    assign b_nz_s       = b_valid && (b_addr != {AW{1'b0}});
    assign fifo_empty_s = (count_s == 2'd0);
    assign b_ready      = (count_s != 2'd2);
    assign push_s       = b_valid && b_ready && b_nz_s;
    assign push_req_s   = '{addr: b_addr, data: b_data};

    wb_fifo #(.req_t(req_t)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push_s),
        .pop         (pop_s),
        .push_req    (push_req_s),
        .head        (head_s),
        .count       (count_s),
        .entries     (entries_s),
        .entry_valid (entry_valid_s)
    );

    // Grant selection; x0 requests are acknowledged but never granted.
    always_comb begin
        grant_a_s = 1'b0;
        pop_s     = 1'b0;
        a_ready   = 1'b1;
        case (state_r)
            PRIO_A: begin
                grant_a_s = a_nz_s;
                pop_s     = !a_nz_s && !fifo_empty_s;
                a_ready   = 1'b1;
            end
            FORCE_B: begin
                grant_a_s = 1'b0;
                pop_s     = !fifo_empty_s;
                a_ready   = !a_nz_s;
            end
            default: begin
                grant_a_s = 1'b0;
                pop_s     = 1'b0;
                a_ready   = 1'b0;
            end
        endcase
    end

    // Read-after-write hazard against buffered entries and the write in flight.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
            if (entry_valid_s[i] &&
                (addr_match(q_ad1, entries_s[i].addr) || addr_match(q_ad2, entries_s[i].addr))) begin
                hazard = 1'b1;
            end else begin
                hazard = hazard;
            end
        end
        if (we3 && (addr_match(q_ad1, ad3) || addr_match(q_ad2, ad3))) begin
            hazard = 1'b1;
        end else begin
            hazard = hazard;
        end
    end

    // Arbitration FSM, starvation counter and registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= PRIO_A;
            starve_cnt_r <= {CW{1'b0}};
            we3          <= 1'b0;
            ad3          <= {AW{1'b0}};
            wd3          <= {DW{1'b0}};
        end else begin
            we3 <= grant_a_s || pop_s;
            if (grant_a_s) begin
                ad3 <= a_addr;
                wd3 <= a_data;
            end else if (pop_s) begin
                ad3 <= head_s.addr;
                wd3 <= head_s.data;
            end
            case (state_r)
                PRIO_A: begin
                    if (grant_a_s && !fifo_empty_s) begin
                        starve_cnt_r <= starve_cnt_r + CW'(1);
                        if (starve_cnt_r == CW'(STARVE_LIMIT - 1)) begin
                            state_r <= FORCE_B;
                        end
                    end else if (fifo_empty_s || pop_s) begin
                        starve_cnt_r <= {CW{1'b0}};
                    end
                end
                FORCE_B: begin
                    state_r      <= PRIO_A;
                    starve_cnt_r <= {CW{1'b0}};
                end
                default: begin
                    state_r      <= PRIO_A;
                    starve_cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Randomized and directed bench for reg_wb_arbiter against a queue-based
// reference model of the arbitration, FIFO and hazard rules.
module tb_reg_wb_arbiter;
    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, b_valid;
    logic [AW-1:0] a_addr, b_addr, q_ad1, q_ad2, ad3;
    logic [DW-1:0] a_data, b_data, wd3;
    logic          a_ready, b_ready, hazard, we3;

    always #5 clk = ~clk;

    reg_wb_arbiter #(
        .REG_FILE_ADDR_WIDTH (AW),
        .DATA_WIDTH          (DW),
        .STARVE_LIMIT        (LIM)
    ) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .q_ad1(q_ad1), .q_ad2(q_ad2), .hazard(hazard),
        .we3(we3), .ad3(ad3), .wd3(wd3)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: pending B writes as a queue, the write in flight, and
    // how many times A has jumped ahead of waiting B work.
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;
    ent_t          mq[$];
    logic          m_we;
    logic [AW-1:0] m_ad;
    logic [DW-1:0] m_wd;
    int            m_wins;
    bit            m_force;
    logic          last_ar, last_br;

    task automatic model_reset();
        mq.delete();
        m_we = 1'b0; m_ad = '0; m_wd = '0; m_wins = 0; m_force = 1'b0;
    endtask

    function automatic bit pending_hit(input logic [AW-1:0] q);
        if (q == '0) return 1'b0;
        foreach (mq[i]) if (mq[i].addr == q) return 1'b1;
        return m_we && (m_ad == q);
    endfunction

    task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] adt,
                        input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bdt,
                        input logic [AW-1:0] q1, input logic [AW-1:0] q2);
        bit   a_nz, b_nz, empty, grant_a, pop, room;
        ent_t e;
        @(negedge clk);
        a_valid = av; a_addr = aa; a_data = adt;
        b_valid = bv; b_addr = ba; b_data = bdt;
        q_ad1 = q1; q_ad2 = q2;
        #1;
        a_nz  = av && (aa != '0);
        b_nz  = bv && (ba != '0);
        empty = (mq.size() == 0);
        room  = (mq.size() < 2);
        check_eq("a_ready", a_ready, m_force ? !a_nz : 1'b1);
        check_eq("b_ready", b_ready, room);
        check_eq("hazard", hazard, pending_hit(q1) || pending_hit(q2));
        last_ar = a_ready;
        last_br = b_ready;
        grant_a = !m_force && a_nz;
        pop     = !grant_a && !empty && (m_force || !a_nz);
        if (grant_a) begin
            m_we = 1'b1; m_ad = aa; m_wd = adt;
        end else if (pop) begin
            e = mq.pop_front();
            m_we = 1'b1; m_ad = e.addr; m_wd = e.data;
        end else begin
            m_we = 1'b0;
        end
        if (bv && room && b_nz) mq.push_back('{addr: ba, data: bdt});
        if (m_force) begin
            m_force = 1'b0; m_wins = 0;
        end else if (grant_a && !empty) begin
            m_wins++;
            if (m_wins == LIM) m_force = 1'b1;
        end else begin
            m_wins = 0;
        end
        @(posedge clk);
        #1;
        check_eq("we3", we3, m_we);
        check_eq("ad3", ad3, m_ad);
        check_eq("wd3", wd3, m_wd);
    endtask

    task automatic idle(input int n, input logic [AW-1:0] q1);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, q1, '0);
    endtask

    initial begin
        logic          av, bv;
        logic [AW-1:0] aa, ba, q1, q2;
        logic [DW-1:0] adt, bdt;
        int            guard;
        logic [AW-1:0] next_a;

        rst = 1'b1;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        q_ad1 = '0; q_ad2 = '0;
        last_ar = 1'b1; last_br = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_we3", we3, 1'b0);
        check_eq("rst_ad3", ad3, '0);
        check_eq("rst_wd3", wd3, '0);
        check_eq("rst_a_ready", a_ready, 1'b1);
        check_eq("rst_b_ready", b_ready, 1'b1);
        check_eq("rst_hazard", hazard, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Single A write, then the port goes quiet.
        step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, '0, '0);
        idle(1, 5'd5);

        // B to x0 is swallowed.
        step(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234_5678, 5'd0, '0);
        idle(2, 5'd0);

        // Starvation: B waits behind a stream of A writes, then gets forced in.
        step(1'b1, 5'd1, 32'h0000_0001, 1'b1, 5'd7, 32'h7777_0007, '0, '0);
        next_a = 5'd2;
        guard  = 0;
        while (next_a <= 5'd6 && guard < 20) begin
            step(1'b1, next_a, {27'd0, next_a}, 1'b0, '0, '0, 5'd7, '0);
            if (last_ar) next_a = next_a + 5'd1;
            guard++;
        end
        check_eq("starve_bound", guard < 20, 1'b1);
        idle(2, '0);

        // FIFO holds 9 and 10 while A is busy, then drains back to back.
        step(1'b1, 5'd1, 32'hA1, 1'b1, 5'd9, 32'h0909, '0, '0);
        step(1'b1, 5'd2, 32'hA2, 1'b1, 5'd10, 32'h1010, 5'd9, '0);
        idle(3, 5'd10);

        // Randomized traffic honouring the hold-while-not-ready rule.
        av = 1'b0; bv = 1'b0; aa = '0; ba = '0; adt = '0; bdt = '0;
        for (int n = 0; n < 1500; n++) begin
            if (!(av && !last_ar)) begin
                av  = ($urandom_range(0, 9) < 7);
                aa  = AW'($urandom_range(0, 7));
                adt = $urandom;
            end
            if (!(bv && !last_br)) begin
                bv  = ($urandom_range(0, 9) < 4);
                ba  = AW'($urandom_range(0, 7));
                bdt = $urandom;
            end
            q1 = AW'($urandom_range(0, 7));
            q2 = AW'($urandom_range(0, 7));
            step(av, aa, adt, bv, ba, bdt, q1, q2);
        end
        idle(4, '0);

        // Fill the FIFO, hold a third B, then reset mid-burst.
        step(1'b1, 5'd1, 32'hB1, 1'b1, 5'd3, 32'h0303, '0, '0);
        step(1'b1, 5'd2, 32'hB2, 1'b1, 5'd4, 32'h0404, '0, 5'd4);
        step(1'b1, 5'd3, 32'hB3, 1'b1, 5'd5, 32'h0505, '0, 5'd4);
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("midrst_we3", we3, 1'b0);
        check_eq("midrst_b_ready", b_ready, 1'b1);
        check_eq("midrst_hazard", hazard, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(3, 5'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
